sliding_window: RTL and testbench

SLIDING_WINDOW -- requirements
Module: sliding_window

---
 rtl/sliding_window.sv | 73 +++++++
 tb/tb_sliding_window.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sliding_window.sv
// KxK sliding window built from a stream of K-pixel columns, with a one-deep
// output stage, per-line border marking and an end-of-frame marker.
module sliding_window #(
    parameter int DATA_WIDTH   = 8,
    parameter int KERNEL_WIDTH = 3,
    parameter int IMG_WIDTH    = 854,
    parameter int IMG_HEIGHT   = 480
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [KERNEL_WIDTH*DATA_WIDTH-1:0]              col_data,
    input  logic                                        col_valid,
    output logic                                        col_ready,
    output logic [KERNEL_WIDTH*KERNEL_WIDTH*DATA_WIDTH-1:0] window_data,
    output logic                                        window_valid,
    input  logic                                        window_ready,
    output logic                                        border_flag,
    output logic                                        window_last
);
    localparam int K        = KERNEL_WIDTH;
    localparam int DW       = DATA_WIDTH;
    localparam int OUT_ROWS = IMG_HEIGHT - K + 1;
    localparam int CW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW       = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;

    localparam logic [CW-1:0] BORDER_X = CW'(K - 1);
    localparam logic [CW-1:0] LAST_X   = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_Y   = RW'(OUT_ROWS - 1);

    logic [CW-1:0]         col_cnt;
    logic [RW-1:0]         row_cnt;
    logic                  col_acc;
    logic                  col_wrap;
    logic                  row_wrap;
    logic [K*K*DW-1:0]     window_next;

    // Output stage is free if empty or being drained this cycle.
    assign col_ready = !window_valid || window_ready;
    assign col_acc   = col_valid && col_ready;
    assign col_wrap  = (col_cnt == LAST_X);
    assign row_wrap  = (row_cnt == LAST_Y);

    always_comb begin
        window_next = window_data;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++)
                window_next[(r*K+c)*DW +: DW] = window_data[(r*K+c+1)*DW +: DW];
            window_next[(r*K+K-1)*DW +: DW] = col_data[r*DW +: DW];
        end
    end

    // Window contents are never flushed at line/frame wrap; border_flag marks stale columns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_data  <= '0;
            window_valid <= 1'b0;
            border_flag  <= 1'b0;
            window_last  <= 1'b0;
            col_cnt      <= '0;
            row_cnt      <= '0;
        end else if (col_acc) begin
            window_data  <= window_next;
            window_valid <= 1'b1;
            border_flag  <= (col_cnt < BORDER_X);
            window_last  <= col_wrap && row_wrap;
            col_cnt      <= col_wrap ? '0 : col_cnt + CW'(1);
            if (col_wrap)
                row_cnt <= row_wrap ? '0 : row_cnt + RW'(1);
        end else if (window_ready) begin
            window_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sliding_window.sv
// Self-checking bench for sliding_window (K=3, 8x5 image) against a column-history model.
module tb_sliding_window;
    localparam int K  = 3;
    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 5;
    localparam int OR = H - K + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [K*DW-1:0]   col_data = '0;
    logic              col_valid = 1'b0;
    logic              col_ready;
    logic [K*K*DW-1:0] window_data;
    logic              window_valid;
    logic              window_ready = 1'b0;
    logic              border_flag;
    logic              window_last;

    sliding_window #(.DATA_WIDTH(DW), .KERNEL_WIDTH(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .col_data(col_data), .col_valid(col_valid), .col_ready(col_ready),
        .window_data(window_data), .window_valid(window_valid), .window_ready(window_ready),
        .border_flag(border_flag), .window_last(window_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: every accepted column since reset, in order.
    logic [K*DW-1:0]   hist [0:511];
    int                hist_n = 0;
    logic              mvalid = 1'b0;
    logic              obs_ready;
    logic              last_wacc;
    logic [K*K*DW-1:0] pre_data;
    logic              pre_last;

    function automatic logic [K*K*DW-1:0] exp_win(input int idx);
        logic [K*K*DW-1:0] w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) begin
                int j = idx - (K - 1) + c;
                if (j >= 0) w[(r*K+c)*DW +: DW] = hist[j][r*DW +: DW];
            end
        return w;
    endfunction

    function automatic logic exp_border(input int idx);
        return (idx % W) < (K - 1);
    endfunction

    function automatic logic exp_last(input int idx);
        return (idx % (W * OR)) == (W * OR - 1);
    endfunction

    // One clock: drive, predict the handshake from the model, advance.
    task automatic step(input logic cv, input logic [K*DW-1:0] cd, input logic wr);
        logic acc;
        col_valid = cv; col_data = cd; window_ready = wr;
        @(negedge clk);
        obs_ready = col_ready;
        pre_data  = window_data;
        pre_last  = window_last;
        last_wacc = mvalid && wr;
        acc = cv && (!mvalid || wr);
        if (acc) begin hist[hist_n] = cd; hist_n++; end
        mvalid = acc ? 1'b1 : (wr ? 1'b0 : mvalid);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        #3 rst = 1'b1;
        hist_n = 0; mvalid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        col_valid = 1'b0; window_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({window_valid, border_flag, window_last, window_data} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h required 0", {window_valid, border_flag, window_last, window_data});
        end
        rst = 1'b0; #1;
        checks++;
        if (col_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", col_ready); end
        step(1'b1, 24'hAABBCC, 1'b1);
        step(1'b1, 24'h112233, 1'b1);
        #3 rst = 1'b1; #1;
        checks++;
        if ({window_valid, border_flag, window_last, window_data} !== '0) begin
            errors++; $display("FAIL midcycle_reset: got %h required 0", {window_valid, border_flag, window_last, window_data});
        end
        hist_n = 0; mvalid = 1'b0;
        @(posedge clk); #1 rst = 1'b0; col_valid = 1'b0; #1;
        checks++;
        if (col_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b required 1", col_ready); end
    endtask

    task automatic test_stream();
        int nwin = 0;
        for (int n = 0; n < 8; n++) begin
            step(1'b1, {8'(32 + n), 8'(16 + n), 8'(n)}, 1'b1);
            if (window_valid === 1'b1) nwin++;
            checks++;
            if (window_data !== exp_win(hist_n - 1) || border_flag !== exp_border(hist_n - 1)) begin
                errors++; $display("FAIL stream_win%0d: got %h/%b required %h/%b", n, window_data, border_flag,
                                   exp_win(hist_n - 1), exp_border(hist_n - 1));
            end
            if (n == 2) begin
                checks++;
                if (window_data[23:0] !== 24'h020100 || window_data[71:48] !== 24'h222120 || border_flag !== 1'b0) begin
                    errors++; $display("FAIL stream_win3_rows: got %h %h %b required 020100 222120 0",
                                       window_data[23:0], window_data[71:48], border_flag);
                end
            end
        end
        checks++;
        if (nwin != 8) begin errors++; $display("FAIL stream_count: got %0d required 8", nwin); end
    endtask

    task automatic test_line_wrap();
        step(1'b1, {8'd40, 8'd24, 8'd8}, 1'b1);
        checks++;
        if (border_flag !== 1'b1 || window_data[7:0] !== 8'd6 || window_data[15:8] !== 8'd7 || window_data[23:16] !== 8'd8) begin
            errors++; $display("FAIL line_wrap: got border %b row0 %h required 1 080706", border_flag, window_data[23:0]);
        end
    endtask

    task automatic test_backpressure();
        logic [K*K*DW-1:0] hold;
        step(1'b0, '0, 1'b1);
        checks++;
        if (window_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got valid %b required 0", window_valid); end
        step(1'b1, {8'd41, 8'd25, 8'd9}, 1'b0);
        checks++;
        if (window_valid !== 1'b1 || window_data !== exp_win(hist_n - 1)) begin
            errors++; $display("FAIL bp_accept: got %b/%h required 1/%h", window_valid, window_data, exp_win(hist_n - 1));
        end
        hold = window_data;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, {8'd42, 8'd26, 8'd10}, 1'b0);
            checks++;
            if (obs_ready !== 1'b0 || window_data !== hold || window_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold%0d: got ready %b data %h required 0 %h", i, obs_ready, window_data, hold);
            end
        end
        step(1'b1, {8'd42, 8'd26, 8'd10}, 1'b1);
        checks++;
        if (obs_ready !== 1'b1 || window_data[23:16] !== 8'd10 || window_data !== exp_win(hist_n - 1)) begin
            errors++; $display("FAIL bp_release: got ready %b data %h required 1 %h", obs_ready, window_data, exp_win(hist_n - 1));
        end
    endtask

    task automatic test_frame_last();
        int lasts = 0;
        while (hist_n < W * OR) begin
            step(1'b1, 24'($urandom), 1'b1);
            if (window_last === 1'b1) lasts++;
            checks++;
            if (window_last !== exp_last(hist_n - 1) || border_flag !== exp_border(hist_n - 1)) begin
                errors++; $display("FAIL frame_col%0d: got last %b border %b required %b %b", hist_n - 1,
                                   window_last, border_flag, exp_last(hist_n - 1), exp_border(hist_n - 1));
            end
        end
        checks++;
        if (lasts != 1 || window_last !== 1'b1) begin
            errors++; $display("FAIL frame_last_count: got %0d (last now %b) required 1 (1)", lasts, window_last);
        end
        step(1'b1, 24'($urandom), 1'b1);
        checks++;
        if (border_flag !== 1'b1 || window_last !== 1'b0 || window_data !== exp_win(hist_n - 1)) begin
            errors++; $display("FAIL frame_restart: got border %b last %b required 1 0", border_flag, window_last);
        end
    endtask

    task automatic test_random();
        int consumed = 0;
        int lasts = 0;
        int cyc = 0;
        logic exp_ready;
        do_reset();
        while ((hist_n < 3 * W * OR || mvalid) && cyc < 3000) begin
            logic cv, wr;
            cv = ($urandom_range(0, 9) < 7);
            wr = (hist_n >= 3 * W * OR) ? 1'b1 : ($urandom_range(0, 9) < 6);
            if (hist_n >= 3 * W * OR) cv = 1'b0;
            exp_ready = !mvalid || wr;
            step(cv, 24'($urandom), wr);
            cyc++;
            checks++;
            if (obs_ready !== exp_ready || window_valid !== mvalid) begin
                errors++; $display("FAIL rand_hs@%0d: got ready %b valid %b required %b %b", cyc, obs_ready, window_valid, exp_ready, mvalid);
            end
            if (last_wacc) begin
                checks++;
                if (pre_data !== exp_win(consumed) || pre_last !== exp_last(consumed)) begin
                    errors++; $display("FAIL rand_consume%0d: got %h/%b required %h/%b", consumed, pre_data, pre_last,
                                       exp_win(consumed), exp_last(consumed));
                end
                if (pre_last === 1'b1) lasts++;
                consumed++;
            end
            if (mvalid) begin
                checks++;
                if (window_data !== exp_win(hist_n - 1) || border_flag !== exp_border(hist_n - 1) || window_last !== exp_last(hist_n - 1)) begin
                    errors++; $display("FAIL rand_win%0d: got %h/%b/%b required %h/%b/%b", hist_n - 1, window_data, border_flag,
                                       window_last, exp_win(hist_n - 1), exp_border(hist_n - 1), exp_last(hist_n - 1));
                end
            end
        end
        checks++;
        if (consumed != 3 * W * OR || lasts != 3) begin
            errors++; $display("FAIL rand_totals: got %0d windows %0d lasts required %0d 3 (cycles %0d)", consumed, lasts, 3 * W * OR, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_line_wrap();
        test_backpressure();
        test_frame_last();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
